// File: rtl/key_table_builder_if.sv
// Key byte stream between the key-entry front end and the table builder.
// The producer drives key_valid/key_char and the builder answers with key_ready.
interface key_table_builder_if;
  logic       key_valid;
  logic [7:0] key_char;
  logic       key_ready;

  modport master (output key_valid, output key_char, input key_ready);
  modport slave  (input key_valid, input key_char, output key_ready);
endinterface

// File: rtl/key_table_builder.sv
// Key table builder: loads a KEY_LEN-byte key over a valid/ready stream,
// rejects non-alphanumeric or repeated bytes, then fills a TABLE_DIM x TABLE_DIM
// substitution table one cell per cycle and serves it through a registered read port.
module key_table_builder #(
  parameter int TABLE_DIM = 7,
  parameter int KEY_LEN   = 12,
  parameter int CASE_FOLD = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  key_table_builder_if.slave           key_bus,
  output logic                         busy,
  output logic                         table_valid,
  output logic                         err_repeated_char,
  output logic                         err_invalid_key_char,
  input  logic [$clog2(TABLE_DIM)-1:0] rd_row,
  input  logic [$clog2(TABLE_DIM)-1:0] rd_col,
  output logic [7:0]                   rd_data
);

  localparam int N    = TABLE_DIM - 1;
  localparam int RC_W = $clog2(TABLE_DIM);
  localparam int KC_W = $clog2(KEY_LEN + 1);

  // A key of the wrong length cannot populate the border row/column exactly once.
  if (KEY_LEN != 2 * (TABLE_DIM - 1)) begin : g_bad_key_len
    $error("key_table_builder: KEY_LEN must equal 2*(TABLE_DIM-1)");
  end
  if (TABLE_DIM < 2 || TABLE_DIM > 7) begin : g_bad_dim
    $error("key_table_builder: TABLE_DIM must be in 2..7");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BUILD = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        key_mem [KEY_LEN];
  logic [KC_W-1:0]   key_cnt;
  logic [7:0]        cells [TABLE_DIM][TABLE_DIM];
  logic [RC_W-1:0]   build_row;
  logic [RC_W-1:0]   build_col;

  logic              accept;
  logic              bad_char;
  logic              repeat_hit;
  logic              byte_err;
  logic              last_byte;
  logic              last_cell;
  logic [7:0]        cell_val;
  int                ri;
  int                ci;
  int                m;
  int                kidx;
  logic              use_key;

  // Alphanumeric ASCII: '0'-'9', 'A'-'Z', 'a'-'z'.
  function automatic logic is_key_char(input logic [7:0] ch);
    return ((ch >= 8'h30) && (ch <= 8'h39)) ||
           ((ch >= 8'h41) && (ch <= 8'h5A)) ||
           ((ch >= 8'h61) && (ch <= 8'h7A));
  endfunction

  // Map lower case onto upper case when the repeat check is case-insensitive.
  function automatic logic [7:0] fold_char(input logic [7:0] ch);
    if ((CASE_FOLD != 0) && (ch >= 8'h61) && (ch <= 8'h7A)) begin
      return ch - 8'h20;
    end else begin
      return ch;
    end
  endfunction

  assign key_bus.key_ready = (state == S_LOAD) && !start;
  assign accept            = key_bus.key_valid && key_bus.key_ready;
  assign busy              = (state == S_LOAD) || (state == S_BUILD);
  assign table_valid       = (state == S_DONE);
  assign last_byte         = (key_cnt == KC_W'(KEY_LEN - 1));
  assign last_cell         = (build_row == RC_W'(N)) && (build_col == RC_W'(N));

  // Validate the incoming byte against the character set and all bytes stored so far.
  always_comb begin
    bad_char   = !is_key_char(key_bus.key_char);
    repeat_hit = 1'b0;
    for (int j = 0; j < KEY_LEN; j++) begin
      repeat_hit = repeat_hit |
                   ((KC_W'(j) < key_cnt) &&
                    (fold_char(key_mem[j]) == fold_char(key_bus.key_char)));
    end
    byte_err = bad_char | repeat_hit;
  end

  // Value of the cell currently addressed by the build counters.
  always_comb begin
    ri       = int'(build_row);
    ci       = int'(build_col);
    m        = 0;
    kidx     = 0;
    use_key  = 1'b0;
    cell_val = 8'h00;
    if ((ri == 0) && (ci == 0)) begin
      cell_val = 8'h00;
    end else if (ci == 0) begin
      use_key = 1'b1;
      kidx    = ((ri % 2) == 1) ? (ri - 1) : (KEY_LEN - ri);
    end else if (ri == 0) begin
      use_key = 1'b1;
      kidx    = ((ci % 2) == 1) ? ci : (KEY_LEN + 1 - ci);
    end else begin
      m        = (ri - 1) * N + (ci - 1);
      cell_val = (m < 26) ? (8'h61 + 8'(m)) : (8'h30 + 8'(m - 26));
    end
    for (int j = 0; j < KEY_LEN; j++) begin
      if (use_key && (j == kidx)) begin
        cell_val = key_mem[j];
      end else begin
        cell_val = cell_val;
      end
    end
  end

  // Next-state logic; start restarts the key load from any non-idle state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
        else       state_next = S_IDLE;
      end
      S_LOAD: begin
        if (start)                      state_next = S_LOAD;
        else if (accept && byte_err)    state_next = S_ERROR;
        else if (accept && last_byte)   state_next = S_BUILD;
        else                            state_next = S_LOAD;
      end
      S_BUILD: begin
        if (start)          state_next = S_LOAD;
        else if (last_cell) state_next = S_DONE;
        else                state_next = S_BUILD;
      end
      S_DONE: begin
        if (start) state_next = S_LOAD;
        else       state_next = S_DONE;
      end
      S_ERROR: begin
        if (start) state_next = S_LOAD;
        else       state_next = S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Key capture, error flags and table construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt              <= '0;
      build_row            <= '0;
      build_col            <= '0;
      err_repeated_char    <= 1'b0;
      err_invalid_key_char <= 1'b0;
      for (int j = 0; j < KEY_LEN; j++) key_mem[j] <= 8'h00;
      for (int r = 0; r < TABLE_DIM; r++)
        for (int c = 0; c < TABLE_DIM; c++) cells[r][c] <= 8'h00;
    end else if (start) begin
      key_cnt              <= '0;
      build_row            <= '0;
      build_col            <= '0;
      err_repeated_char    <= 1'b0;
      err_invalid_key_char <= 1'b0;
      for (int r = 0; r < TABLE_DIM; r++)
        for (int c = 0; c < TABLE_DIM; c++) cells[r][c] <= 8'h00;
    end else begin
      if (accept) begin
        if (byte_err) begin
          err_repeated_char    <= err_repeated_char | repeat_hit;
          err_invalid_key_char <= err_invalid_key_char | bad_char;
        end else begin
          key_mem[key_cnt] <= key_bus.key_char;
          key_cnt          <= key_cnt + KC_W'(1);
        end
      end
      if (state == S_BUILD) begin
        cells[build_row][build_col] <= cell_val;
        if (build_col == RC_W'(N)) begin
          build_col <= '0;
          build_row <= build_row + RC_W'(1);
        end else begin
          build_col <= build_col + RC_W'(1);
        end
      end
    end
  end

  // Registered read port; zero unless a completed table is addressed in range.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      rd_data <= 8'h00;
    end else if ((state == S_DONE) && (int'(rd_row) < TABLE_DIM) &&
                 (int'(rd_col) < TABLE_DIM)) begin
      rd_data <= cells[rd_row][rd_col];
    end else begin
      rd_data <= 8'h00;
    end
  end

endmodule
